uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_rr_pick.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART TX message arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } tx_state_t;

  localparam logic [7:0] HEADER_BASE_DEFAULT = 8'hA0;

  function automatic logic [7:0] header_byte(input logic [7:0] base, input logic [2:0] idx);
    return base | {5'b00000, idx};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set req bit strictly after rr_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         rr_ptr,
  output logic               found,
  output logic [2:0]         index
);

  always_comb begin
    found = 1'b0;
    index = 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
          found = 1'b1;
          index = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one TX FIFO write port among NUM_REQ message sources; a grant holds
// until the owner's last byte or until the owner stalls for TIMEOUT_CYCLES.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NUM_REQ        = 4,
  parameter int         HEADER_EN      = 1,
  parameter logic [7:0] HEADER_BASE    = HEADER_BASE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 52080
) (
  input  logic                 CLOCK_50,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data,
  input  logic [NUM_REQ-1:0]   last,
  output logic [NUM_REQ-1:0]   ack,
  input  logic                 fifo_full,
  output logic                 fifo_we,
  output logic [7:0]           fifo_data,
  output logic                 busy,
  output logic [2:0]           owner,
  output logic                 abort
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  tx_state_t     state;
  logic [2:0]    rr_ptr;
  logic [CW-1:0] stall_cnt;

  logic          pick_found;
  logic [2:0]    pick_index;
  logic          own_req;
  logic          own_last;
  logic [7:0]    own_data;
  logic          pay_write;
  logic          stall;
  logic          timeout;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_index)
  );

  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == 3'(i)) begin
        own_req  = req[i];
        own_last = last[i];
        own_data = data[8*i +: 8];
      end
    end
  end

  assign pay_write = (state == ST_PAYLOAD) && own_req && !fifo_full;
  assign stall     = (state == ST_PAYLOAD) && !own_req;
  assign timeout   = stall && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign abort     = timeout;
  assign busy      = (state != ST_IDLE);

  // Write port and acks decode straight from registered state so a byte moves the same cycle it is offered.
  always_comb begin
    ack       = '0;
    fifo_we   = 1'b0;
    fifo_data = 8'h00;
    case (state)
      ST_HEADER: begin
        fifo_we   = !fifo_full;
        fifo_data = header_byte(HEADER_BASE, owner);
      end
      ST_PAYLOAD: begin
        fifo_we   = pay_write;
        fifo_data = own_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner == 3'(i)) ack[i] = pay_write;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= 3'(NUM_REQ - 1);
      owner     <= 3'd0;
      stall_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          stall_cnt <= '0;
          if (pick_found) begin
            owner <= pick_index;
            state <= (HEADER_EN != 0) ? ST_HEADER : ST_PAYLOAD;
          end
        end
        ST_HEADER: begin
          if (!fifo_full) state <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          // A full FIFO with the owner still offering a byte is not a stall.
          if (pay_write) begin
            stall_cnt <= '0;
            if (own_last) begin
              state  <= ST_IDLE;
              rr_ptr <= owner;
            end
          end else if (timeout) begin
            state     <= ST_IDLE;
            rr_ptr    <= owner;
            stall_cnt <= '0;
          end else if (stall) begin
            stall_cnt <= stall_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: requester queues feed the arbiter, expected FIFO bytes are
// queued with the stimulus and popped as writes appear.
module tb_uart_tx_arbiter;

  logic        clock_50 = 1'b0;
  logic        rst;
  logic        fifo_full;

  logic [3:0]  req_a;
  logic [31:0] data_a;
  logic [3:0]  last_a;
  logic [3:0]  ack_a;
  logic        fifo_we_a;
  logic [7:0]  fifo_data_a;
  logic        busy_a;
  logic [2:0]  owner_a;
  logic        abort_a;

  logic [1:0]  req_b;
  logic [15:0] data_b;
  logic [1:0]  last_b;
  logic [1:0]  ack_b;
  logic        fifo_full_b;
  logic        fifo_we_b;
  logic [7:0]  fifo_data_b;
  logic        busy_b;
  logic [2:0]  owner_b;
  logic        abort_b;

  int          checks_total  = 0;
  int          checks_passed = 0;
  int          ack_cnt [4];
  int          abort_cnt = 0;
  int          wr_cnt    = 0;
  logic [8:0]  stim_q [4][$];
  logic [7:0]  exp_q [$];

  always #5 clock_50 = ~clock_50;

  uart_tx_arbiter #(
    .NUM_REQ(4), .HEADER_EN(1), .HEADER_BASE(8'hA0), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .CLOCK_50(clock_50), .rst(rst), .req(req_a), .data(data_a), .last(last_a),
    .ack(ack_a), .fifo_full(fifo_full), .fifo_we(fifo_we_a), .fifo_data(fifo_data_a),
    .busy(busy_a), .owner(owner_a), .abort(abort_a)
  );

  uart_tx_arbiter #(
    .NUM_REQ(2), .HEADER_EN(0)
  ) dut_b (
    .CLOCK_50(clock_50), .rst(rst), .req(req_b), .data(data_b), .last(last_b),
    .ack(ack_b), .fifo_full(fifo_full_b), .fifo_we(fifo_we_b), .fifo_data(fifo_data_b),
    .busy(busy_b), .owner(owner_b), .abort(abort_b)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input logic l);
    stim_q[i].push_back({l, d});
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stim_q[i].delete();
      ack_cnt[i] = 0;
    end
    exp_q.delete();
    abort_cnt = 0;
    repeat (2) @(posedge clock_50);
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clock_50);
      #1;
      n++;
      done = (exp_q.size() == 0) && !busy_a && (stim_q[0].size() == 0) &&
             (stim_q[1].size() == 0) && (stim_q[2].size() == 0) && (stim_q[3].size() == 0);
    end
    check_output("drain", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n;
    n = 0;
    while (wr_cnt < target && n < budget) begin
      @(negedge clock_50);
      #1;
      n++;
    end
    check_output("write_wait", {31'b0, wr_cnt >= target}, 32'd1);
  endtask

  // Requester models present the head of their queue just after each rising edge.
  always @(posedge clock_50) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (stim_q[i].size() > 0) begin
        req_a[i]        = 1'b1;
        data_a[8*i +: 8] = stim_q[i][0][7:0];
        last_a[i]       = stim_q[i][0][8];
      end else begin
        req_a[i]        = 1'b0;
        data_a[8*i +: 8] = 8'h00;
        last_a[i]       = 1'b0;
      end
    end
  end

  always @(negedge clock_50) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (ack_a[i]) begin
          ack_cnt[i]++;
          if (stim_q[i].size() > 0) void'(stim_q[i].pop_front());
        end
      end
      if (abort_a) abort_cnt++;
      if (fifo_we_a) begin
        wr_cnt++;
        if (exp_q.size() == 0) check_output("spurious_write", {24'b0, fifo_data_a}, 32'h100);
        else check_output("fifo_byte", {24'b0, fifo_data_a}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int cycles;
    logic saw_we, saw_ack, saw_abort, hit;

    rst = 1'b1;
    fifo_full = 1'b0;
    fifo_full_b = 1'b0;
    req_a = '0; data_a = '0; last_a = '0;
    req_b = '0; data_b = '0; last_b = '0;
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;

    @(negedge clock_50);
    check_output("rst_busy", {31'b0, busy_a}, 32'd0);
    check_output("rst_we", {31'b0, fifo_we_a}, 32'd0);
    check_output("rst_ack", {28'b0, ack_a}, 32'd0);
    check_output("rst_abort", {31'b0, abort_a}, 32'd0);
    check_output("rst_data", {24'b0, fifo_data_a}, 32'h00);
    check_output("rst_owner", {29'b0, owner_a}, 32'd0);
    @(posedge clock_50);
    #1 rst = 1'b0;

    $display("[TB] two-byte message from requester 0");
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b1);
    expect_byte(8'hA0); expect_byte(8'h41); expect_byte(8'h42);
    wait_done(100);
    check_output("ack0_count", ack_cnt[0], 32'd2);
    check_output("busy_after_msg", {31'b0, busy_a}, 32'd0);

    $display("[TB] all four requesters, two rounds");
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        push_byte(i, 8'(8'h10 + 16 * r + i), 1'b1);
        expect_byte(8'(8'hA0 | i));
        expect_byte(8'(8'h10 + 16 * r + i));
      end
      wait_done(200);
    end
    for (int i = 0; i < 4; i++) check_output($sformatf("rr_ack%0d", i), ack_cnt[i], 32'd2);

    $display("[TB] fifo_full held during payload");
    base = wr_cnt;
    push_byte(1, 8'h31, 1'b0); push_byte(1, 8'h32, 1'b0); push_byte(1, 8'h33, 1'b1);
    expect_byte(8'hA1); expect_byte(8'h31); expect_byte(8'h32); expect_byte(8'h33);
    wait_writes(base + 2, 50);
    @(posedge clock_50);
    #1 fifo_full = 1'b1;
    saw_we = 1'b0; saw_ack = 1'b0; saw_abort = 1'b0;
    repeat (10) begin
      @(negedge clock_50);
      if (fifo_we_a) saw_we = 1'b1;
      if (|ack_a) saw_ack = 1'b1;
      if (abort_a) saw_abort = 1'b1;
    end
    check_output("full_no_we", {31'b0, saw_we}, 32'd0);
    check_output("full_no_ack", {31'b0, saw_ack}, 32'd0);
    check_output("full_no_abort", {31'b0, saw_abort}, 32'd0);
    check_output("full_owner", {29'b0, owner_a}, 32'd1);
    @(posedge clock_50);
    #1 fifo_full = 1'b0;
    wait_done(100);

    $display("[TB] owner 2 stalls until timeout");
    base = wr_cnt;
    push_byte(2, 8'h51, 1'b0);
    push_byte(3, 8'h61, 1'b1);
    expect_byte(8'hA2); expect_byte(8'h51); expect_byte(8'hA3); expect_byte(8'h61);
    wait_writes(base + 2, 50);
    cycles = 0;
    hit = 1'b0;
    while (!hit && cycles < 100) begin
      @(negedge clock_50);
      cycles++;
      if (abort_a) hit = 1'b1;
    end
    check_output("stall_cycles", cycles, 32'd16);
    @(negedge clock_50);
    check_output("abort_pulse_len", {31'b0, abort_a}, 32'd0);
    check_output("idle_after_abort", {31'b0, busy_a}, 32'd0);
    wait_done(100);
    check_output("abort_count", abort_cnt, 32'd1);

    $display("[TB] reset mid-message");
    base = wr_cnt;
    push_byte(1, 8'h71, 1'b0);
    push_byte(1, 8'h72, 1'b1);
    expect_byte(8'hA1); expect_byte(8'h71);
    wait_writes(base + 2, 50);
    @(posedge clock_50);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) stim_q[i].delete();
    #1;
    check_output("midrst_we", {31'b0, fifo_we_a}, 32'd0);
    check_output("midrst_ack", {28'b0, ack_a}, 32'd0);
    check_output("midrst_busy", {31'b0, busy_a}, 32'd0);
    check_output("midrst_data", {24'b0, fifo_data_a}, 32'h00);
    check_output("midrst_pending", exp_q.size(), 32'd0);
    repeat (2) @(posedge clock_50);
    #1 rst = 1'b0;
    push_byte(0, 8'h81, 1'b1);
    push_byte(1, 8'h91, 1'b1);
    expect_byte(8'hA0); expect_byte(8'h81); expect_byte(8'hA1); expect_byte(8'h91);
    wait_done(100);

    $display("[TB] headerless configuration");
    @(posedge clock_50);
    #1;
    req_b = 2'b10; data_b = 16'h5500; last_b = 2'b10;
    @(negedge clock_50);
    check_output("nohdr_grant_cycle_we", {31'b0, fifo_we_b}, 32'd0);
    @(negedge clock_50);
    check_output("nohdr_we", {31'b0, fifo_we_b}, 32'd1);
    check_output("nohdr_data", {24'b0, fifo_data_b}, 32'h55);
    check_output("nohdr_ack", {30'b0, ack_b}, 32'd2);
    @(posedge clock_50);
    #1;
    req_b = 2'b00; data_b = 16'h0000; last_b = 2'b00;
    @(negedge clock_50);
    check_output("nohdr_idle", {31'b0, busy_b}, 32'd0);
    check_output("nohdr_no_abort", {31'b0, abort_b}, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
